// File: rtl/pciexp_tx_sym_sched.sv
// pciexp_tx_sym_sched: per-lane TX symbol scheduler ahead of the 8b/10b encoder.
// Optional electrical-idle ordered sets: define PCIEXP_TXSCHED_EIOS_EN.
module pciexp_tx_sym_sched #(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned CNT_W        = 11
) (
  input  logic       PCLK250,
  input  logic       Reset_N,
  input  logic       TxEnable_P2,
  input  logic       TxValid_P2,
  input  logic [7:0] TxData_P2,
  input  logic       TxKCode_P2,
  input  logic       TxEnd_P2,
`ifdef PCIEXP_TXSCHED_EIOS_EN
  input  logic       TxElecIdleReq_P2,
  output logic       TxElecIdle_P2,
`endif
  output logic       TxReady_P2,
  output logic [7:0] EncData_P2,
  output logic       EncKCode_P2,
  output logic       EncUseNegDisp_P2,
  output logic       EncReset_P2,
  output logic       SkpActive_P2
);

  typedef enum logic [3:0] {
    OFF,
    IDLE,
    PKT,
    SKP1,
    SKP2,
    SKP3
`ifdef PCIEXP_TXSCHED_EIOS_EN
    ,
    EIOS1,
    EIOS2,
    EIOS3,
    EI
`endif
  } state_t;

  localparam logic [7:0] D00   = 8'h00;
  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_SKP = 8'h1C;
`ifdef PCIEXP_TXSCHED_EIOS_EN
  localparam logic [7:0] K_IDL = 8'h7C;
`endif
  localparam logic [CNT_W-1:0] CNT_TOP =
    CNT_W'(SKP_INTERVAL - 1);
  localparam logic [CNT_W-1:0] CNT_PRE =
    CNT_W'(SKP_INTERVAL - 2);

  state_t           st, st_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             skp_pend, pend_n;
  logic [7:0]       data_n;
  logic             k_n, nd_n, er_n, sa_n;
  logic             com, cnt_en, acc;
`ifdef PCIEXP_TXSCHED_EIOS_EN
  logic             ei_pend, eip_n, eid_n;
  logic             ei_go;

  assign ei_go = TxElecIdleReq_P2 | ei_pend;
`endif

  assign acc = TxValid_P2 & TxReady_P2;

  always_comb begin
    TxReady_P2 = 1'b0;
    unique case (st)
      IDLE: begin
        TxReady_P2 = ~skp_pend;
`ifdef PCIEXP_TXSCHED_EIOS_EN
        TxReady_P2 = ~skp_pend & ~ei_go;
`endif
      end
      PKT:     TxReady_P2 = 1'b1;
      default: TxReady_P2 = 1'b0;
    endcase
  end

  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    pend_n = skp_pend;
    data_n = D00;
    k_n    = 1'b0;
    nd_n   = 1'b0;
    er_n   = 1'b0;
    sa_n   = 1'b0;
    com    = 1'b0;
    cnt_en = 1'b1;
`ifdef PCIEXP_TXSCHED_EIOS_EN
    eip_n  = ei_pend;
    eid_n  = 1'b0;
`endif
    unique case (st)
      OFF: begin
        er_n   = 1'b1;
        cnt_en = 1'b0;
        if (TxEnable_P2) begin
          st_n = IDLE;
          er_n = 1'b0;
          nd_n = 1'b1;
        end
      end
      IDLE: begin
`ifdef PCIEXP_TXSCHED_EIOS_EN
        if (ei_go) begin
          data_n = K_COM;
          k_n    = 1'b1;
          eip_n  = 1'b0;
          st_n   = EIOS1;
        end else
`endif
        if (skp_pend) begin
          data_n = K_COM;
          k_n    = 1'b1;
          sa_n   = 1'b1;
          com    = 1'b1;
          st_n   = SKP1;
        end else if (acc) begin
          data_n = TxData_P2;
          k_n    = TxKCode_P2;
          if (!TxEnd_P2) st_n = PKT;
        end
      end
      PKT: begin
        if (acc) begin
          data_n = TxData_P2;
          k_n    = TxKCode_P2;
          if (TxEnd_P2) st_n = IDLE;
        end
      end
      SKP1, SKP2, SKP3: begin
        data_n = K_SKP;
        k_n    = 1'b1;
        sa_n   = 1'b1;
        if (st == SKP1) st_n = SKP2;
        else if (st == SKP2) st_n = SKP3;
        else st_n = IDLE;
      end
`ifdef PCIEXP_TXSCHED_EIOS_EN
      EIOS1, EIOS2, EIOS3: begin
        data_n = K_IDL;
        k_n    = 1'b1;
        if (st == EIOS1) st_n = EIOS2;
        else if (st == EIOS2) st_n = EIOS3;
        else st_n = EI;
      end
      EI: begin
        // hold at least one cycle so TxElecIdle is seen
        cnt_en = 1'b0;
        cnt_n  = '0;
        pend_n = 1'b0;
        er_n   = 1'b1;
        eid_n  = 1'b1;
        if (!TxElecIdleReq_P2 && TxElecIdle_P2) begin
          st_n  = IDLE;
          er_n  = 1'b0;
          eid_n = 1'b0;
          nd_n  = 1'b1;
        end
      end
`endif
      default: st_n = OFF;
    endcase
`ifdef PCIEXP_TXSCHED_EIOS_EN
    if (TxElecIdleReq_P2 &&
        (st == PKT || st == SKP1 ||
         st == SKP2 || st == SKP3))
      eip_n = 1'b1;
`endif
    if (com) begin
      cnt_n  = '0;
      pend_n = 1'b0;
    end else if (cnt_en && cnt != CNT_TOP) begin
      cnt_n = cnt + CNT_W'(1);
      if (cnt == CNT_PRE) pend_n = 1'b1;
    end
    if (!TxEnable_P2) begin
      st_n   = OFF;
      data_n = D00;
      k_n    = 1'b0;
      nd_n   = 1'b0;
      er_n   = 1'b1;
      sa_n   = 1'b0;
      cnt_n  = '0;
      pend_n = 1'b0;
`ifdef PCIEXP_TXSCHED_EIOS_EN
      eip_n  = 1'b0;
      eid_n  = 1'b0;
`endif
    end
  end

  always_ff @(posedge PCLK250 or negedge Reset_N) begin
    if (!Reset_N) begin
      st               <= OFF;
      cnt              <= '0;
      skp_pend         <= 1'b0;
      EncData_P2       <= D00;
      EncKCode_P2      <= 1'b0;
      EncUseNegDisp_P2 <= 1'b0;
      EncReset_P2      <= 1'b1;
      SkpActive_P2     <= 1'b0;
`ifdef PCIEXP_TXSCHED_EIOS_EN
      ei_pend          <= 1'b0;
      TxElecIdle_P2    <= 1'b0;
`endif
    end else begin
      st               <= st_n;
      cnt              <= cnt_n;
      skp_pend         <= pend_n;
      EncData_P2       <= data_n;
      EncKCode_P2      <= k_n;
      EncUseNegDisp_P2 <= nd_n;
      EncReset_P2      <= er_n;
      SkpActive_P2     <= sa_n;
`ifdef PCIEXP_TXSCHED_EIOS_EN
      ei_pend          <= eip_n;
      TxElecIdle_P2    <= eid_n;
`endif
    end
  end

endmodule

// File: tb/tb_pciexp_tx_sym_sched.sv
// tb_pciexp_tx_sym_sched: directed stimulus against a symbol-level lane model.
// Uses SKP_INTERVAL=16; PCIEXP_TXSCHED_EIOS_EN adds the electrical-idle case.
`timescale 1ns/1ps
module tb_pciexp_tx_sym_sched;
  localparam int SKP = 16;

  logic       PCLK250 = 1'b0;
  logic       Reset_N = 1'b0;
  logic       TxEnable_P2 = 1'b0;
  logic       TxValid_P2 = 1'b0;
  logic [7:0] TxData_P2 = 8'h00;
  logic       TxKCode_P2 = 1'b0;
  logic       TxEnd_P2 = 1'b0;
  logic       TxReady_P2;
  logic [7:0] EncData_P2;
  logic       EncKCode_P2;
  logic       EncUseNegDisp_P2;
  logic       EncReset_P2;
  logic       SkpActive_P2;
`ifdef PCIEXP_TXSCHED_EIOS_EN
  logic       TxElecIdleReq_P2 = 1'b0;
  logic       TxElecIdle_P2;
`endif

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  pciexp_tx_sym_sched #(.SKP_INTERVAL(SKP), .CNT_W(5)) dut (
    .PCLK250          (PCLK250),
    .Reset_N          (Reset_N),
    .TxEnable_P2      (TxEnable_P2),
    .TxValid_P2       (TxValid_P2),
    .TxData_P2        (TxData_P2),
    .TxKCode_P2       (TxKCode_P2),
    .TxEnd_P2         (TxEnd_P2),
`ifdef PCIEXP_TXSCHED_EIOS_EN
    .TxElecIdleReq_P2 (TxElecIdleReq_P2),
    .TxElecIdle_P2    (TxElecIdle_P2),
`endif
    .TxReady_P2       (TxReady_P2),
    .EncData_P2       (EncData_P2),
    .EncKCode_P2      (EncKCode_P2),
    .EncUseNegDisp_P2 (EncUseNegDisp_P2),
    .EncReset_P2      (EncReset_P2),
    .SkpActive_P2     (SkpActive_P2)
  );

  always #2 PCLK250 = ~PCLK250;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  // Lane model: symbols since last COM, SKPs still owed, packet in flight
  bit         m_on, m_inpkt, m_due;
  int         m_since, m_skp_left;
  logic [7:0] e_data;
  logic       e_k, e_nd, e_rst, e_sa;

  function automatic bit m_ready();
    return m_on && m_skp_left == 0 && (m_inpkt || !m_due);
  endfunction

  task automatic m_off();
    m_on = 0; m_inpkt = 0; m_due = 0; m_since = 0; m_skp_left = 0;
    e_data = 8'h00; e_k = 0; e_nd = 0; e_rst = 1; e_sa = 0;
  endtask

  always @(posedge PCLK250 or negedge Reset_N) begin
    bit rdy;
    bit counted;
    if (!Reset_N || !TxEnable_P2) begin
      m_off();
    end else if (!m_on) begin
      m_on = 1;
      e_data = 8'h00; e_k = 0; e_nd = 1; e_rst = 0; e_sa = 0;
    end else begin
      rdy = m_ready();
      counted = 1;
      e_nd = 0; e_rst = 0; e_sa = 0;
      if (m_skp_left > 0) begin
        e_data = 8'h1C; e_k = 1; e_sa = 1;
        m_skp_left--;
      end else if (!m_inpkt && m_due) begin
        e_data = 8'hBC; e_k = 1; e_sa = 1;
        m_skp_left = 3; m_due = 0; m_since = 0; counted = 0;
      end else if (TxValid_P2 && rdy) begin
        e_data = TxData_P2; e_k = TxKCode_P2;
        m_inpkt = !TxEnd_P2;
      end else begin
        e_data = 8'h00; e_k = 0;
      end
      if (counted) begin
        m_since++;
        if (m_since >= SKP - 1) m_due = 1;
      end
    end
  end

  always @(posedge PCLK250) begin
    #1;
    if (chk_on)
      chk("cycle", {EncData_P2, EncKCode_P2, EncUseNegDisp_P2,
                    EncReset_P2, SkpActive_P2, TxReady_P2},
          {e_data, e_k, e_nd, e_rst, e_sa, m_ready()});
  end

  task automatic idle_in();
    TxValid_P2 = 0; TxData_P2 = 8'h00; TxKCode_P2 = 0; TxEnd_P2 = 0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge PCLK250);
  endtask

  task automatic wait_com();
    int n = 0;
    while (!(SkpActive_P2 && EncData_P2 == 8'hBC) && n < 100) begin
      @(negedge PCLK250);
      n++;
    end
    if (n >= 100) bound_fail("wait_com");
  endtask

  // From current negedge, cycles until the next COM; counts TxReady=0 cycles
  task automatic com_gap(output int g, output int lo);
    g = 0;
    lo = 0;
    do begin
      if (!TxReady_P2) lo++;
      @(negedge PCLK250);
      g++;
    end while (!(SkpActive_P2 && EncData_P2 == 8'hBC) && g < 100);
    if (g >= 100) bound_fail("com_gap");
  endtask

  task automatic send_pkt(input int n, output int stalls);
    int i = 0;
    int guard = 0;
    logic [7:0] d;
    logic k, e;
    bit sent;
    stalls = 0;
    while (i < n && guard < 4 * n + 50) begin
      d = (i == 0) ? 8'hFB : (i == n - 1) ? 8'hFD : 8'(i);
      k = (i == 0 || i == n - 1);
      e = (i == n - 1);
      TxValid_P2 = 1; TxData_P2 = d; TxKCode_P2 = k; TxEnd_P2 = e;
      sent = TxReady_P2;
      if (!sent) stalls++;
      @(negedge PCLK250);
      guard++;
      if (sent) begin
        chk("pkt_fwd", {EncKCode_P2, EncData_P2}, {k, d});
        i++;
      end
    end
    idle_in();
    if (i < n) bound_fail("send_pkt");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, lo, st;
    TxEnable_P2 = 1;
    idle_in();
    m_off();
    step(3);
    chk("rst_encreset", EncReset_P2, 1);
    chk("rst_data", EncData_P2, 0);
    chk("rst_negdisp", EncUseNegDisp_P2, 0);
    chk("rst_skp", SkpActive_P2, 0);
    chk("rst_ready", TxReady_P2, 0);
    chk_on = 1;
    Reset_N = 1;
    step(1);
    chk("start_negdisp", EncUseNegDisp_P2, 1);
    chk("start_encreset", EncReset_P2, 0);
    chk("start_data", {EncKCode_P2, EncData_P2}, 0);
    step(1);
    chk("negdisp_one_cycle", EncUseNegDisp_P2, 0);

    send_pkt(4, st);
    chk("pkt4_stalls", st, 0);

    wait_com();
    com_gap(g, lo);
    chk("idle_skp_gap", g, SKP);
    chk("idle_ready_low", lo, 4);
    chk("com_sym", {SkpActive_P2, EncKCode_P2, EncData_P2}, 10'h3BC);
    step(1);
    chk("skp_sym1", {SkpActive_P2, EncKCode_P2, EncData_P2}, 10'h31C);
    step(1);
    chk("skp_sym2", {SkpActive_P2, EncKCode_P2, EncData_P2}, 10'h31C);
    step(1);
    chk("skp_sym3", {SkpActive_P2, EncKCode_P2, EncData_P2}, 10'h31C);
    step(1);
    chk("post_skp", {SkpActive_P2, EncKCode_P2, EncData_P2}, 10'h000);

    step(6);
    send_pkt(40, st);
    chk("pkt40_stalls", st, 0);
    step(1);
    chk("com_after_end", {SkpActive_P2, EncKCode_P2, EncData_P2}, 10'h3BC);
    com_gap(g, lo);
    chk("gap_after_pkt", g, SKP);

    step(1);
    TxEnable_P2 = 0;
    step(1);
    chk("dis_encreset", EncReset_P2, 1);
    chk("dis_data", {SkpActive_P2, EncKCode_P2, EncData_P2}, 0);
    step(2);
    chk("dis_ready", TxReady_P2, 0);
    TxEnable_P2 = 1;
    step(1);
    chk("reen_negdisp", EncUseNegDisp_P2, 1);
    chk("reen_encreset", EncReset_P2, 0);
    com_gap(g, lo);
    chk("reen_gap", g, SKP);
    chk("reen_ready_low", lo, 1);

    step(1);
    #1 Reset_N = 0;
    #0.5;
    chk("arst_encreset", EncReset_P2, 1);
    chk("arst_out", {SkpActive_P2, EncKCode_P2, EncData_P2}, 0);
    chk("arst_ready", TxReady_P2, 0);
    @(negedge PCLK250);
    Reset_N = 1;
    step(1);
    chk("arst_negdisp", EncUseNegDisp_P2, 1);
    com_gap(g, lo);
    chk("arst_gap", g, SKP);

`ifdef PCIEXP_TXSCHED_EIOS_EN
    chk_on = 0;
    TxEnable_P2 = 0;
    step(2);
    TxEnable_P2 = 1;
    step(2);
    for (int i = 0; i < 4; i++) begin
      TxValid_P2 = 1;
      TxData_P2 = (i == 0) ? 8'hFB : (i == 3) ? 8'hFD : 8'(i);
      TxKCode_P2 = (i == 0 || i == 3);
      TxEnd_P2 = (i == 3);
      TxElecIdleReq_P2 = (i == 1);
      chk("ei_pkt_ready", TxReady_P2, 1);
      step(1);
      chk("ei_pkt_fwd", EncData_P2, TxData_P2);
    end
    idle_in();
    TxElecIdleReq_P2 = 0;
    step(1);
    chk("eios_com", {SkpActive_P2, EncKCode_P2, EncData_P2}, 10'h1BC);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("eios_idl", {SkpActive_P2, EncKCode_P2, EncData_P2}, 10'h17C);
    end
    step(1);
    chk("ei_state", {TxElecIdle_P2, EncReset_P2}, 2'b11);
    step(1);
    chk("ei_exit", {TxElecIdle_P2, EncReset_P2, EncUseNegDisp_P2}, 3'b001);
    chk("ei_exit_data", EncData_P2, 0);
`endif

    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
